// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter that shares one 3-to-8 select decoder among 8 requesters.
// Holds each grant until DONE, request drop or hold limit, then rotates priority.
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] REQ,
  input  logic       DONE,
  output logic       GNT_VALID,
  output logic [2:0] GNT_IDX,
  output logic [7:0] GNT_ONEHOT,
  output logic       TIMEOUT,
  output logic       state_dbg
);

  // Handshake: REQ[i] is a level; the holder keeps REQ[i] high while it wants the
  // resource and ends the grant by pulsing DONE or dropping REQ[i]. GNT_VALID and
  // GNT_ONEHOT move together on the same edge; one idle cycle separates grants.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;
  logic [2:0]        last_idx;
  logic [2:0]        last_idx_nxt;
  logic [2:0]        idx_nxt;
  logic [7:0]        onehot_nxt;
  logic              valid_nxt;
  logic              timeout_nxt;

  logic [2:0]        cand;
  logic [2:0]        win_idx;
  logic              win_found;

  logic              rel_done;
  logic              rel_drop;
  logic              rel_limit;
  logic              release_now;

  assign state_dbg = state;

  // Search starts one past the previous winner, so the previous winner comes last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_idx + 3'(k);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rel_done    = DONE;
  assign rel_drop    = !REQ[GNT_IDX];
  assign rel_limit   = (hold_cnt == HOLD_LAST);
  assign release_now = (state == S_GRANT) && (rel_done || rel_drop || rel_limit);

  // State register together with the registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      GNT_VALID  <= 1'b0;
      GNT_IDX    <= 3'd0;
      GNT_ONEHOT <= 8'h00;
      TIMEOUT    <= 1'b0;
      hold_cnt   <= '0;
      last_idx   <= 3'd7;
    end else begin
      state      <= state_nxt;
      GNT_VALID  <= valid_nxt;
      GNT_IDX    <= idx_nxt;
      GNT_ONEHOT <= onehot_nxt;
      TIMEOUT    <= timeout_nxt;
      hold_cnt   <= hold_cnt_nxt;
      last_idx   <= last_idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = S_GRANT;
      S_GRANT: if (release_now) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    valid_nxt    = GNT_VALID;
    idx_nxt      = GNT_IDX;
    onehot_nxt   = GNT_ONEHOT;
    timeout_nxt  = 1'b0;
    hold_cnt_nxt = hold_cnt;
    last_idx_nxt = last_idx;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          valid_nxt    = 1'b1;
          idx_nxt      = win_idx;
          onehot_nxt   = 8'h01 << win_idx;
          last_idx_nxt = win_idx;
          hold_cnt_nxt = '0;
        end else begin
          valid_nxt  = 1'b0;
          onehot_nxt = 8'h00;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          valid_nxt   = 1'b0;
          onehot_nxt  = 8'h00;
          // DONE and request drop are voluntary releases and mask the timeout.
          timeout_nxt = rel_limit && !rel_done && !rel_drop;
        end else begin
          hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        valid_nxt  = 1'b0;
        onehot_nxt = 8'h00;
      end
    endcase
  end

  a_onehot0: assert property (@(posedge CLK) disable iff (!RST_N)
    $onehot0(GNT_ONEHOT));

  a_decode: assert property (@(posedge CLK) disable iff (!RST_N)
    GNT_ONEHOT == (GNT_VALID ? (8'h01 << GNT_IDX) : 8'h00));

  a_hold_bound: assert property (@(posedge CLK) disable iff (!RST_N)
    GNT_VALID |-> (hold_cnt <= HOLD_LAST));

  a_valid_state: assert property (@(posedge CLK) disable iff (!RST_N)
    GNT_VALID == (state == S_GRANT));

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: rotation order, wrap, hold limit,
// release precedence and reset mid-grant, with hand-computed expectations.
module tb_rr_decoder_arbiter;

  logic       CLK;
  logic       RST_N;
  logic [7:0] REQ;
  logic       DONE;
  logic       GNT_VALID;
  logic [2:0] GNT_IDX;
  logic [7:0] GNT_ONEHOT;
  logic       TIMEOUT;
  logic       state_dbg;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_idx;

  rr_decoder_arbiter #(
    .MAX_HOLD(16),
    .HOLD_W  (5)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ       (REQ),
    .DONE      (DONE),
    .GNT_VALID (GNT_VALID),
    .GNT_IDX   (GNT_IDX),
    .GNT_ONEHOT(GNT_ONEHOT),
    .TIMEOUT   (TIMEOUT),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  // Checking
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [2:0] idx, input logic to);
    logic [7:0] oh;
    oh = v ? (8'h01 << idx) : 8'h00;
    check_eq({tag, ".valid"},   32'(GNT_VALID),  32'(v));
    check_eq({tag, ".idx"},     32'(GNT_IDX),    32'(idx));
    check_eq({tag, ".onehot"},  32'(GNT_ONEHOT), 32'(oh));
    check_eq({tag, ".timeout"}, 32'(TIMEOUT),    32'(to));
    check_eq({tag, ".state"},   32'(state_dbg),  32'(v));
  endtask

  always @(negedge CLK) begin
    if (mon_en && RST_N === 1'b1)
      check_eq("onehot0", 32'($onehot0(GNT_ONEHOT)), 32'd1);
  end

  // Stimulus
  initial begin
    RST_N = 1'b0;
    REQ   = 8'h00;
    DONE  = 1'b0;
    tick();
    tick();
    expect_out("reset", 1'b0, 3'd0, 1'b0);
    RST_N  = 1'b1;
    mon_en = 1'b1;

    // First grant goes to requester 0, one cycle after REQ
    REQ = 8'h01;
    tick();
    expect_out("first", 1'b1, 3'd0, 1'b0);
    REQ = 8'h00;
    tick();
    expect_out("first_rel", 1'b0, 3'd0, 1'b0);

    // Full rotation with all requesting, one dead cycle each
    apply_reset();
    for (int n = 0; n < 9; n++) exp_q.push_back(3'(n));
    REQ = 8'hFF;
    while (exp_q.size() > 0) begin
      exp_idx = exp_q.pop_front();
      tick();
      expect_out("rr_grant", 1'b1, exp_idx, 1'b0);
      DONE = 1'b1;
      tick();
      expect_out("rr_dead", 1'b0, exp_idx, 1'b0);
      DONE = 1'b0;
    end
    REQ = 8'h00;
    tick();

    // Wrap: last_idx=6 with REQ=90 -> 7, then 4
    apply_reset();
    REQ = 8'h40;
    tick();
    expect_out("wrap_pre", 1'b1, 3'd6, 1'b0);
    REQ = 8'h00;
    tick();
    REQ = 8'h90;
    tick();
    expect_out("wrap_7", 1'b1, 3'd7, 1'b0);
    DONE = 1'b1;
    tick();
    expect_out("wrap_7_rel", 1'b0, 3'd7, 1'b0);
    DONE = 1'b0;
    tick();
    expect_out("wrap_4", 1'b1, 3'd4, 1'b0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    REQ  = 8'h00;
    tick();

    // Hold limit: 16 valid cycles, then TIMEOUT pulse
    REQ = 8'h08;
    tick();
    expect_out("hold_start", 1'b1, 3'd3, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
      expect_out("hold", 1'b1, 3'd3, 1'b0);
    end
    tick();
    expect_out("hold_timeout", 1'b0, 3'd3, 1'b1);
    tick();
    expect_out("hold_regrant", 1'b1, 3'd3, 1'b0);
    for (int i = 1; i < 16; i++) tick();
    expect_out("hold_last", 1'b1, 3'd3, 1'b0);
    // DONE on the limit cycle suppresses the timeout
    DONE = 1'b1;
    tick();
    expect_out("hold_done_prec", 1'b0, 3'd3, 1'b0);
    DONE = 1'b0;
    REQ  = 8'h00;
    tick();
    expect_out("hold_idle", 1'b0, 3'd3, 1'b0);

    // Request drop mid-hold; other requests ignored during grant
    apply_reset();
    REQ = 8'h04;
    tick();
    expect_out("drop_grant", 1'b1, 3'd2, 1'b0);
    tick();
    REQ = 8'h05;
    tick();
    expect_out("drop_ignore", 1'b1, 3'd2, 1'b0);
    REQ = 8'h01;
    tick();
    expect_out("drop_rel", 1'b0, 3'd2, 1'b0);
    tick();
    expect_out("drop_next", 1'b1, 3'd0, 1'b0);
    REQ = 8'h00;
    tick();
    expect_out("drop_next_rel", 1'b0, 3'd0, 1'b0);

    // Reset during grant, then grant 7
    REQ = 8'h20;
    tick();
    expect_out("rst_pre", 1'b1, 3'd5, 1'b0);
    tick();
    RST_N = 1'b0;
    tick();
    expect_out("rst_mid", 1'b0, 3'd0, 1'b0);
    RST_N = 1'b1;
    REQ   = 8'h80;
    tick();
    expect_out("rst_after", 1'b1, 3'd7, 1'b0);
    REQ = 8'h00;
    tick();
    expect_out("rst_after_rel", 1'b0, 3'd7, 1'b0);
    DONE = 1'b1;
    tick();
    expect_out("done_idle", 1'b0, 3'd7, 1'b0);
    DONE = 1'b0;
    tick();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
